// File: rtl/led_pkg.sv
// Shared types and constants for the LED mode scheduler.
//   mode_e        : display mode, OFF=0 BLINK=1 CHASE=2 COUNT=3
//   LED_W         : width of the LED pattern
//   init_pattern  : pattern loaded when a mode is entered
package led_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] INIT_OFF   = 8'h00;
  localparam logic [LED_W-1:0] INIT_BLINK = 8'h00;
  localparam logic [LED_W-1:0] INIT_CHASE = 8'h01;
  localparam logic [LED_W-1:0] INIT_COUNT = 8'h00;

  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_OFF:   p = INIT_OFF;
      MODE_BLINK: p = INIT_BLINK;
      MODE_CHASE: p = INIT_CHASE;
      MODE_COUNT: p = INIT_COUNT;
      default:    p = INIT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
//   CLOCK_50 : clock
//   RESET    : async active-high reset
//   clr      : clear count to 0 (wins over en)
//   en       : advance count; when low the count holds and tick is suppressed
//   tick     : one-cycle pulse every TICK_DIV enabled cycles
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter wraps to 0 on the same edge the tick is consumed
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/led_mode_scheduler.sv
// LED mode scheduler: KEY[0] steps the display mode, KEY[1] toggles pause,
// and each prescaler tick updates LEDG according to the current mode.
//   CLOCK_50 : clock
//   RESET    : async active-high reset
//   KEY[1:0] : active-low debounced pushbuttons
//   LEDG     : registered LED pattern
//   MODE     : registered current mode
//   PAUSED   : registered pause flag
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [1:0]       KEY,
  output logic [LED_W-1:0] LEDG,
  output logic [1:0]       MODE,
  output logic             PAUSED
);

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_prev;
  logic [1:0]       r_warm;
  logic [1:0]       w_press;
  logic             w_tick;

  mode_e            r_mode;
  mode_e            w_mode_next;
  logic [LED_W-1:0] r_led;
  logic [LED_W-1:0] w_led_next;
  logic             r_paused;
  logic             w_paused_next;

  // Synchronizer, previous-value flop and post-reset warm-up counter
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_prev  <= 2'b11;
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Presses are ignored until r_prev holds a real key sample, so a key held
  // low across reset cannot look like a fresh 1->0 edge.
  assign w_press = (r_warm == 2'd3) ? (r_prev & ~r_sync2) : 2'b00;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clr      (w_press[0]),
    .en       (~r_paused),
    .tick     (w_tick)
  );

  // Mode, pattern and pause state registers
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_mode   <= MODE_OFF;
      r_led    <= '0;
      r_paused <= 1'b0;
    end else begin
      r_mode   <= w_mode_next;
      r_led    <= w_led_next;
      r_paused <= w_paused_next;
    end
  end

  // Next state: a mode change discards any coincident tick
  always_comb begin
    w_mode_next   = r_mode;
    w_led_next    = r_led;
    w_paused_next = r_paused;

    if (w_press[0]) begin
      case (r_mode)
        MODE_OFF:   w_mode_next = MODE_BLINK;
        MODE_BLINK: w_mode_next = MODE_CHASE;
        MODE_CHASE: w_mode_next = MODE_COUNT;
        MODE_COUNT: w_mode_next = MODE_OFF;
        default:    w_mode_next = MODE_OFF;
      endcase
      w_led_next = init_pattern(w_mode_next);
    end else if (w_tick) begin
      case (r_mode)
        MODE_OFF:   w_led_next = '0;
        MODE_BLINK: w_led_next = ~r_led;
        MODE_CHASE: w_led_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
        MODE_COUNT: w_led_next = r_led + LED_W'(1);
        default:    w_led_next = '0;
      endcase
    end

    if (w_press[1]) w_paused_next = ~r_paused;
  end

  assign LEDG   = r_led;
  assign MODE   = r_mode;
  assign PAUSED = r_paused;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Self-checking bench for led_mode_scheduler with TICK_DIV=4.
module tb_led_mode_scheduler;

  localparam int unsigned TICK_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b0;
  logic [1:0] KEY      = 2'b11;
  logic [7:0] LEDG;
  logic [1:0] MODE;
  logic       PAUSED;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  led_mode_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .LEDG     (LEDG),
    .MODE     (MODE),
    .PAUSED   (PAUSED)
  );

  // Reference model: edges counted since reset release, key sample history
  int       m_edges;
  int       m_mode;
  int       m_led;
  int       m_cnt;
  bit       m_paused;
  bit [1:0] h1, h2, h3;   // key samples from 1, 2 and 3 edges ago

  function automatic int next_pattern(input int mode, input int led);
    case (mode)
      0:       return 0;
      1:       return 255 - led;
      2:       return (led == 128) ? 1 : led * 2;
      default: return (led + 1) % 256;
    endcase
  endfunction

  function automatic logic [10:0] exp_out();
    return {2'(m_mode), m_paused, 8'(m_led)};
  endfunction

  task automatic model_reset();
    m_edges = 0; m_mode = 0; m_led = 0; m_cnt = 0; m_paused = 0;
    h1 = 2'b11; h2 = 2'b11; h3 = 2'b11;
  endtask

  // A press lands two edges after the first low sample, provided the
  // sample before it was a genuine post-reset high.
  task automatic model_edge(input bit [1:0] s);
    bit [1:0] p;
    m_edges++;
    for (int b = 0; b < 2; b++) p[b] = (m_edges >= 4) && h3[b] && !h2[b];
    if (p[0]) begin
      m_mode = (m_mode + 1) % 4;
      m_led  = (m_mode == 2) ? 1 : 0;
      m_cnt  = 0;
    end else if (!m_paused) begin
      if (m_cnt == TICK_DIV - 1) begin
        m_cnt = 0;
        m_led = next_pattern(m_mode, m_led);
      end else begin
        m_cnt++;
      end
    end
    if (p[1]) m_paused = !m_paused;
    h3 = h2; h2 = h1; h1 = s;
  endtask

  task automatic step(input logic [1:0] k);
    @(negedge CLOCK_50);
    KEY = k;
    @(posedge CLOCK_50);
    model_edge(k);
    #1;
  endtask

  task automatic test_reset();
    KEY = 2'b11;
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({MODE, PAUSED, LEDG} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", {MODE, PAUSED, LEDG}, 11'h000);
    end
    @(posedge CLOCK_50); @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step(2'b11);
      n_checks++;
      if ({MODE, PAUSED, LEDG} !== 11'h000) begin
        n_fail++;
        $display("FAIL idle cyc%0d: got %h expected %h", i, {MODE, PAUSED, LEDG}, 11'h000);
      end
    end
  endtask

  task automatic test_blink();
    step(2'b10);
    step(2'b11);
    n_checks++;
    if (MODE !== 2'd0) begin
      n_fail++;
      $display("FAIL blink_latency_k1: MODE got %0d expected 0", MODE);
    end
    step(2'b11);
    n_checks++;
    if (MODE !== 2'd1 || LEDG !== 8'h00) begin
      n_fail++;
      $display("FAIL blink_enter: MODE/LEDG got %0d/%h expected 1/00", MODE, LEDG);
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'b11);
      n_checks++;
      if (LEDG !== ((i >= 4 && i < 8) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("FAIL blink_edge%0d: LEDG got %h expected %h", i, LEDG,
                 (i >= 4 && i < 8) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_chase_count();
    logic [7:0] exp;
    step(2'b10); step(2'b11); step(2'b11);
    n_checks++;
    if (MODE !== 2'd2 || LEDG !== 8'h01) begin
      n_fail++;
      $display("FAIL chase_enter: MODE/LEDG got %0d/%h expected 2/01", MODE, LEDG);
    end
    for (int i = 1; i <= 9; i++) begin
      for (int c = 0; c < 4; c++) step(2'b11);
      exp = 8'h01 << (i % 8);
      n_checks++;
      if (LEDG !== exp) begin
        n_fail++;
        $display("FAIL chase_tick%0d: LEDG got %h expected %h", i, LEDG, exp);
      end
    end
    step(2'b10); step(2'b11); step(2'b11);
    n_checks++;
    if (MODE !== 2'd3 || LEDG !== 8'h00) begin
      n_fail++;
      $display("FAIL count_enter: MODE/LEDG got %0d/%h expected 3/00", MODE, LEDG);
    end
    for (int i = 1; i <= 256; i++) begin
      for (int c = 0; c < 4; c++) begin
        step(2'b11);
        n_checks++;
        if ({MODE, PAUSED, LEDG} !== exp_out()) begin
          n_fail++;
          $display("FAIL count_model: got %h expected %h", {MODE, PAUSED, LEDG}, exp_out());
        end
      end
      exp = 8'(i);
      n_checks++;
      if (LEDG !== exp) begin
        n_fail++;
        $display("FAIL count_tick%0d: LEDG got %h expected %h", i, LEDG, exp);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] frozen;
    int         waited;
    for (int g = 0; g < 8 && m_cnt != 3; g++) step(2'b11);
    step(2'b01); step(2'b11); step(2'b11);
    n_checks++;
    if (PAUSED !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_on: PAUSED got %b expected 1", PAUSED);
    end
    frozen = 8'(m_led);
    for (int i = 0; i < 50; i++) begin
      step(2'b11);
      n_checks++;
      if (LEDG !== frozen || PAUSED !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold cyc%0d: LEDG/PAUSED got %h/%b expected %h/1", i, LEDG, PAUSED, frozen);
      end
    end
    step(2'b01); step(2'b11); step(2'b11);
    n_checks++;
    if (PAUSED !== 1'b0 || LEDG !== frozen) begin
      n_fail++;
      $display("FAIL pause_off: LEDG/PAUSED got %h/%b expected %h/0", LEDG, PAUSED, frozen);
    end
    waited = 0;
    while (LEDG === frozen && waited < 10) begin
      step(2'b11);
      waited++;
    end
    n_checks++;
    if (waited != 2 || LEDG !== frozen + 8'd1) begin
      n_fail++;
      $display("FAIL resume_latency: cycles got %0d LEDG %h expected 2 and %h", waited, LEDG, frozen + 8'd1);
    end
  endtask

  task automatic test_simultaneous();
    step(2'b10); step(2'b11); step(2'b11);   // COUNT -> OFF
    step(2'b10); step(2'b11); step(2'b11);   // OFF -> BLINK
    for (int i = 0; i < 6; i++) step(2'b11);
    step(2'b00); step(2'b11); step(2'b11);
    n_checks++;
    if ({MODE, PAUSED, LEDG} !== {2'd2, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL simul_press: got %h expected %h", {MODE, PAUSED, LEDG}, {2'd2, 1'b1, 8'h01});
    end
    for (int i = 0; i < 30; i++) begin
      step(2'b11);
      n_checks++;
      if (LEDG !== 8'h01) begin
        n_fail++;
        $display("FAIL simul_frozen cyc%0d: LEDG got %h expected 01", i, LEDG);
      end
    end
    step(2'b01);
    for (int i = 0; i < 12; i++) begin
      step(2'b11);
      n_checks++;
      if ({MODE, PAUSED, LEDG} !== exp_out()) begin
        n_fail++;
        $display("FAIL simul_resume cyc%0d: got %h expected %h", i, {MODE, PAUSED, LEDG}, exp_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(2'b10); step(2'b11); step(2'b11);   // CHASE -> COUNT
    for (int g = 0; g < 400 && m_led != 8'h37; g++) step(2'b11);
    step(2'b11);
    n_checks++;
    if (MODE !== 2'd3 || LEDG !== 8'h37) begin
      n_fail++;
      $display("FAIL pre_reset: MODE/LEDG got %0d/%h expected 3/37", MODE, LEDG);
    end
    @(negedge CLOCK_50);
    KEY = 2'b10;
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({MODE, PAUSED, LEDG} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", {MODE, PAUSED, LEDG}, 11'h000);
    end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(2'b10);
      n_checks++;
      if (MODE !== 2'd0) begin
        n_fail++;
        $display("FAIL held_key cyc%0d: MODE got %0d expected 0", i, MODE);
      end
    end
    step(2'b11); step(2'b11);
    step(2'b10); step(2'b11); step(2'b11);
    n_checks++;
    if (MODE !== 2'd1) begin
      n_fail++;
      $display("FAIL repress: MODE got %0d expected 1", MODE);
    end
  endtask

  task automatic test_random();
    logic [1:0] k;
    int         hold;
    k = 2'b11;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        k[0] = ($urandom_range(0, 3) != 0);
        k[1] = ($urandom_range(0, 5) != 0);
        hold = $urandom_range(1, 6);
      end
      hold--;
      step(k);
      n_checks++;
      if ({MODE, PAUSED, LEDG} !== exp_out()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", i, {MODE, PAUSED, LEDG}, exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_blink();
    test_chase_count();
    test_pause();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
